// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the 24-bit colour struct and the display-mode enum.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_TILE_SH  = 3;
  localparam int DEF_MEM_LAT  = 1;
  localparam logic [23:0] DEF_BG_RGB = 24'h000000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    MODE_TILE = 1'b0,
    MODE_BAR  = 1'b1
  } mode_e;

endpackage

// File: rtl/vga_tile_renderer_if.sv
// Tile-memory read port: the renderer issues addresses, the tile RAM returns codes.
interface vga_tile_renderer_if #(
  parameter int AW = 13
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_data;

  modport master (output mem_addr, output mem_rd_en, input mem_data);
  modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/vga_timing.sv
// Free-running h/v counters with raw (undelayed) sync, active-area and frame-origin decode.
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic          o_frame,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_end;
  logic          w_h_act;
  logic          w_v_act;

  assign w_h_end = (r_h == HW'(H_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_end) begin
      r_h <= '0;
      r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  assign w_h_act  = (r_h >= HW'(H_START)) && (r_h < HW'(H_START + H_ACTIVE));
  assign w_v_act  = (r_v >= VW'(V_START)) && (r_v < VW'(V_START + V_ACTIVE));
  assign o_hsync  = (r_h >= HW'(H_SYNC));
  assign o_vsync  = (r_v >= VW'(V_SYNC));
  assign o_active = w_h_act && w_v_act;
  assign o_frame  = (r_h == '0) && (r_v == '0);
  // x/y are only meaningful while o_active is high.
  assign o_x      = XW'(r_h - HW'(H_START));
  assign o_y      = YW'(r_v - VW'(V_START));

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile/colour-bar VGA renderer: tile addressing, 3-3-2 colour expansion and output
// alignment so sync, blank and pixel all leave MEM_LAT+1 clocks after the counters.
module vga_tile_renderer import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int TILE_SH  = DEF_TILE_SH,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter logic [23:0] BG_RGB = DEF_BG_RGB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  vga_tile_renderer_if.master        mem,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       vga_blank,
  output logic                       vga_sync,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b,
  output logic                       frame_start
);

  localparam int TILES_X = H_ACTIVE >> TILE_SH;
  localparam int AW      = $clog2(TILES_X * (V_ACTIVE >> TILE_SH));
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int BAR_W   = H_ACTIVE / 8;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
    logic bar;
    rgb_t bar_pix;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, bar: 1'b0, bar_pix: '0};

  function automatic rgb_t tile_rgb(input logic [7:0] c);
    rgb_t v;
    v.r = {c[7:5], c[7:5], c[7:6]};
    v.g = {c[4:2], c[4:2], c[4:3]};
    v.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return v;
  endfunction

  // Bar order white..black maps to r=~i[1], g=~i[2], b=~i[0].
  function automatic rgb_t bar_colour(input logic [2:0] i);
    rgb_t v;
    v.r = {8{~i[1]}};
    v.g = {8{~i[2]}};
    v.b = {8{~i[0]}};
    return v;
  endfunction

  logic          w_hs, w_vs, w_act, w_frame;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [2:0]    w_bar_idx;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  mode_e         r_mode;
  ctl_t          w_ctl_p0;
  ctl_t          r_ctl_p1 [MEM_LAT];
  ctl_t          w_ctl_last;
  rgb_t          w_pix;
  logic          r_hsync_p2, r_vsync_p2, r_blank_p2, r_fs_p2;
  rgb_t          r_pix_p2;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
    .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP),
    .XW(XW), .YW(YW)
  ) u_timing (
    .clk(clk), .rst(rst),
    .o_hsync(w_hs), .o_vsync(w_vs), .o_active(w_act), .o_frame(w_frame),
    .o_x(w_x), .o_y(w_y)
  );

  // Stage p0: counter-aligned addressing and control bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_mode <= MODE_TILE;
    else if (w_frame) r_mode <= mode_e'(mode);
  end

  assign w_bar_idx = 3'(w_x / XW'(BAR_W));
  assign w_rd_en   = w_act && (r_mode == MODE_TILE);
  assign w_addr    = w_rd_en ? (AW'(w_y >> TILE_SH) * AW'(TILES_X) + AW'(w_x >> TILE_SH)) : '0;

  assign mem.mem_rd_en = w_rd_en;
  assign mem.mem_addr  = w_addr;

  always_comb begin
    w_ctl_p0         = CTL_RST;
    w_ctl_p0.hs      = w_hs;
    w_ctl_p0.vs      = w_vs;
    w_ctl_p0.act     = w_act;
    w_ctl_p0.fs      = w_frame;
    w_ctl_p0.bar     = (r_mode == MODE_BAR);
    w_ctl_p0.bar_pix = bar_colour(w_bar_idx);
  end

  // Stage p1: control waits here for the tile code to come back from memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) r_ctl_p1[i] <= CTL_RST;
    end else begin
      r_ctl_p1[0] <= w_ctl_p0;
      for (int i = 1; i < MEM_LAT; i++) r_ctl_p1[i] <= r_ctl_p1[i-1];
    end
  end

  assign w_ctl_last = r_ctl_p1[MEM_LAT-1];

  always_comb begin
    w_pix = '0;
    if (w_ctl_last.act) begin
      if (w_ctl_last.bar)              w_pix = w_ctl_last.bar_pix;
      else if (mem.mem_data == 8'h00)  w_pix = rgb_t'(BG_RGB);
      else                             w_pix = tile_rgb(mem.mem_data);
    end
  end

  // Stage p2: registered video outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync_p2 <= 1'b1;
      r_vsync_p2 <= 1'b1;
      r_blank_p2 <= 1'b0;
      r_fs_p2    <= 1'b0;
      r_pix_p2   <= '0;
    end else begin
      r_hsync_p2 <= w_ctl_last.hs;
      r_vsync_p2 <= w_ctl_last.vs;
      r_blank_p2 <= w_ctl_last.act;
      r_fs_p2    <= w_ctl_last.fs;
      r_pix_p2   <= w_pix;
    end
  end

  assign hsync       = r_hsync_p2;
  assign vsync       = r_vsync_p2;
  assign vga_blank   = r_blank_p2;
  assign vga_sync    = 1'b0;
  assign frame_start = r_fs_p2;
  assign r           = r_pix_p2.r;
  assign g           = r_pix_p2.g;
  assign b           = r_pix_p2.b;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer on a reduced 80x40 raster (64x32 active, 8x4 tiles).
module tb_vga_tile_renderer;

  localparam int H_ACT = 64, H_SY = 8, H_B = 4, H_F = 4;
  localparam int V_ACT = 32, V_SY = 2, V_B = 3, V_F = 3;
  localparam logic [23:0] BG = 24'h123456;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       hsync, vsync, vga_blank, vga_sync, frame_start;
  logic [7:0] r, g, b;
  logic [7:0] tile_mem [32];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  vga_tile_renderer_if #(.AW(5)) mif ();

  vga_tile_renderer #(
    .H_ACTIVE(H_ACT), .H_SYNC(H_SY), .H_BP(H_B), .H_FP(H_F),
    .V_ACTIVE(V_ACT), .V_SYNC(V_SY), .V_BP(V_B), .V_FP(V_F),
    .TILE_SH(3), .MEM_LAT(1), .BG_RGB(BG)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .mem(mif),
    .hsync(hsync), .vsync(vsync), .vga_blank(vga_blank), .vga_sync(vga_sync),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // One-clock-latency tile RAM.
  always @(posedge clk or posedge rst) begin
    if (rst)                    mif.mem_data <= 8'h00;
    else if (mif.mem_rd_en)     mif.mem_data <= tile_mem[mif.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the k-th rising edge since reset release.
  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    for (int i = 0; i < 32; i++) tile_mem[i] = 8'h00;
    tile_mem[0]  = 8'hE0;
    tile_mem[8]  = 8'h1F;
    tile_mem[11] = 8'hFF;
    tile_mem[16] = 8'h1C;
    tile_mem[31] = 8'h96;

    #23;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_blank", 32'(vga_blank), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'h000000);
    chk("rst_rd_en", 32'(mif.mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mif.mem_addr), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("vga_sync", 32'(vga_sync), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    go(1);    chk("e1_hsync", 32'(hsync), 32'd1);
              chk("e1_fs", 32'(frame_start), 32'd0);
    go(2);    chk("e2_hsync", 32'(hsync), 32'd0);
              chk("e2_vsync", 32'(vsync), 32'd0);
              chk("e2_fs", 32'(frame_start), 32'd1);
    go(3);    chk("e3_fs", 32'(frame_start), 32'd0);
    go(9);    chk("hsync_last_low", 32'(hsync), 32'd0);
    go(10);   chk("hsync_high", 32'(hsync), 32'd1);
    go(82);   chk("hsync_period", 32'(hsync), 32'd0);
    go(161);  chk("vsync_last_low", 32'(vsync), 32'd0);
    go(162);  chk("vsync_high", 32'(vsync), 32'd1);

    go(332);  chk("rd_en_vbp", 32'(mif.mem_rd_en), 32'd0);
    go(411);  chk("rd_en_hbp", 32'(mif.mem_rd_en), 32'd0);
    go(412);  chk("rd_en_first", 32'(mif.mem_rd_en), 32'd1);
              chk("addr_first", 32'(mif.mem_addr), 32'd0);
    go(413);  chk("blank_pre", 32'(vga_blank), 32'd0);
              chk("rgb_pre", 32'({r, g, b}), 32'h000000);
    go(414);  chk("blank_first", 32'(vga_blank), 32'd1);
              chk("rgb_E0", 32'({r, g, b}), 32'hFF0000);
    go(420);  chk("addr_tile1", 32'(mif.mem_addr), 32'd1);
    go(422);  chk("rgb_bg", 32'({r, g, b}), 32'(BG));
    go(1052); chk("addr_row1", 32'(mif.mem_addr), 32'd8);
    go(1054); chk("rgb_1F", 32'({r, g, b}), 32'h00FFFF);

    go(1600); mode = 1'b1;
    go(1692); chk("midframe_rd_en", 32'(mif.mem_rd_en), 32'd1);
              chk("addr_row2", 32'(mif.mem_addr), 32'd16);
    go(1694); chk("midframe_tile", 32'({r, g, b}), 32'h00FF00);
    go(2955); chk("addr_last", 32'(mif.mem_addr), 32'd31);
    go(2956); chk("rd_en_hfp", 32'(mif.mem_rd_en), 32'd0);
    go(2957); chk("rgb_96", 32'({r, g, b}), 32'h92B6AA);
    go(2958); chk("blank_post", 32'(vga_blank), 32'd0);
              chk("rgb_post", 32'({r, g, b}), 32'h000000);

    go(3201); chk("f1_fs_pre", 32'(frame_start), 32'd0);
    go(3202); chk("f1_fs", 32'(frame_start), 32'd1);
    go(3612); chk("bar_rd_en", 32'(mif.mem_rd_en), 32'd0);
    go(3614); chk("bar_white", 32'({r, g, b}), 32'hFFFFFF);
    go(3622); chk("bar_yellow", 32'({r, g, b}), 32'hFFFF00);
    go(3646); chk("bar_magenta", 32'({r, g, b}), 32'hFF00FF);
    go(3669); chk("bar_blue", 32'({r, g, b}), 32'h0000FF);
    go(3670); chk("bar_black", 32'({r, g, b}), 32'h000000);
              chk("bar_black_blank", 32'(vga_blank), 32'd1);
    go(3700); mode = 1'b0;
    go(4012); chk("bar_holds", 32'(mif.mem_rd_en), 32'd0);

    go(8040); chk("pre_rst_rd_en", 32'(mif.mem_rd_en), 32'd1);
              chk("pre_rst_addr", 32'(mif.mem_addr), 32'd11);
              chk("pre_rst_rgb", 32'({r, g, b}), 32'hFFFFFF);
    rst = 1'b1;
    #1;
    chk("mid_rst_blank", 32'(vga_blank), 32'd0);
    chk("mid_rst_rgb", 32'({r, g, b}), 32'h000000);
    chk("mid_rst_rd_en", 32'(mif.mem_rd_en), 32'd0);
    chk("mid_rst_addr", 32'(mif.mem_addr), 32'd0);
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    go(1);    chk("rel_blank", 32'(vga_blank), 32'd0);
              chk("rel_rgb", 32'({r, g, b}), 32'h000000);
              chk("rel_hsync", 32'(hsync), 32'd1);
    go(2);    chk("rel_hsync_low", 32'(hsync), 32'd0);
              chk("rel_fs", 32'(frame_start), 32'd1);
    go(10);   chk("rel_hsync_high", 32'(hsync), 32'd1);
    go(82);   chk("rel_hsync_period", 32'(hsync), 32'd0);
    go(90);   chk("rel_hsync_high2", 32'(hsync), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_tile_renderer.md
VGA_TILE_RENDERER -- requirements
Module: vga_tile_renderer

Interface
REQ-001 SHALL take parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL take parameters H_SYNC/H_BP/H_FP, defaults 96/48/16, horizontal sync, back-porch and front-porch widths in clocks.
REQ-003 SHALL take parameters V_ACTIVE/V_SYNC/V_BP/V_FP, defaults 480/2/33/10, same in lines.
REQ-004 SHALL take parameter TILE_SH, default 3, log2 of the square tile edge (8x8 cells).
REQ-005 SHALL take parameter MEM_LAT, default 1, tile-memory read latency in clocks (>=1).
REQ-006 SHALL take parameter BG_RGB, default 24'h000000, colour for tile code 0.
REQ-007 SHALL have ports: clk  in  1  pixel clock; one clock; all logic on rising edge.
REQ-008 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports: mode  in  1  0 = tile display, 1 = colour-bar test pattern.
REQ-010 SHALL have ports: mem_addr  out  AW  tile index, AW = clog2((H_ACTIVE>>TILE_SH)*(V_ACTIVE>>TILE_SH)).
REQ-011 SHALL have ports: mem_rd_en  out  1  read strobe; mem_data  in  8  tile code, valid MEM_LAT clocks after mem_rd_en.
REQ-012 SHALL have ports: hsync, vsync  out  1 each, active-low; vga_blank  out  1, low outside active area; vga_sync  out  1, constant 0.
REQ-013 SHALL have ports: r, g, b  out  8 each; frame_start  out  1, one-clock pulse.

Function
REQ-014 SHALL run counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1 (H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL analogous).
REQ-015 SHALL wrap h to 0 after H_TOTAL-1 and increment v on that same clock; v wraps to 0 after V_TOTAL-1 at h wrap.
REQ-016 SHALL order each line and frame as sync, back porch, active, front porch; active x = h-(H_SYNC+H_BP), active y = v-(V_SYNC+V_BP).
REQ-017 SHALL drive mem_rd_en=1 and mem_addr=(y>>TILE_SH)*(H_ACTIVE>>TILE_SH)+(x>>TILE_SH) in the same clock as the counters when in the active area; else mem_rd_en=0, mem_addr=0.
REQ-018 SHALL produce hsync, vsync, vga_blank, r, g, b for counter state at clock t on clock t+MEM_LAT+1, with all outputs delayed identically.
REQ-019 SHALL, in tile mode, output BG_RGB for code 0; else expand 3-3-2: r={c[7:5],c[7:5],c[7:6]}, g={c[4:2],c[4:2],c[4:3]}, b={c[1:0],c[1:0],c[1:0],c[1:0]}.
REQ-020 SHALL, in bar mode, split H_ACTIVE into 8 equal bars, left to right: white, yellow, cyan, green, magenta, red, blue, black (8'hFF/8'h00 components); mem_rd_en stays 0.
REQ-021 SHALL sample mode only at h=0,v=0; a mid-frame change takes effect next frame.
REQ-022 SHALL force r=g=b=0 whenever delayed vga_blank=0.
REQ-023 SHALL pulse frame_start on the output clock corresponding to h=0,v=0.

Reset
REQ-024 SHALL, while rst=1, set immediately h=0, v=0, hsync=1, vsync=1, vga_blank=0, r=g=b=0, mem_rd_en=0, mem_addr=0, frame_start=0, and clear every pipeline stage to those values; mode register resets to 0.
REQ-025 SHALL start counting at h=0 on the first rising edge after rst falls; reset mid-line or mid-frame discards all in-flight pixels.

Structure
REQ-026 SHALL place default timing constants, an rgb_t struct typedef (r,g,b 8 bits) and the mode enum in shared package vga_pkg.
REQ-027 SHALL isolate the counters and raw sync/active decode in sub-module vga_timing; the renderer adds addressing, colour mapping and delay alignment.

Verification (defaults, MEM_LAT=1, latency 2)
REQ-028 SHALL check: release rst -> hsync low from clock 2 for 96 clocks, period 800; vsync low 1600 clocks, period 420000; frame_start once per 420000.
REQ-029 SHALL check: h=144,v=35 -> mem_addr=0; h=152 -> 1; h=144,v=43 -> 80; last active pixel -> 4799; mem_rd_en=0 at h=143 and h=784.
REQ-030 SHALL check: memory model returns E0 -> r=FF,g=00,b=00 two clocks after address; 00 -> BG_RGB; 1F -> r=00,g=FF,b=FF.
REQ-031 SHALL check: mode=1 asserted at line 100 -> tile output to frame end; next frame h=144 white, h=224 yellow, h=704 black.
REQ-032 SHALL check: rst pulsed at h=400,v=200 -> outputs take reset values in the same clock, no stale pixel after release, hsync period 800 resumes.
